// File: rtl/mirror_range_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mirror_range_scanner
//
// Bus slave that counts the decimal palindromes ("mirror numbers") in the
// inclusive range [LOW, HIGH]. It does this with a sequenced engine: one
// candidate at a time, one decimal digit of that candidate per clock.
//
// Optional build macro: MIRROR_IRQ_EN (adds the oIrq port and the irq_en bit).
//
// Ports:
//   iClk           system clock
//   iReset_n       asynchronous active-low reset
//   iChipSelect_n  slave select, active low
//   iWrite_n       write strobe, active low
//   iRead_n        read strobe, active low
//   iAddress       register address (0 LOW, 1 HIGH, 2 CTRL/STATUS, 3 COUNT)
//   iData          write data
//   oData          registered read data, valid the cycle after the read
//   oIrq           done interrupt level (only with MIRROR_IRQ_EN)
// -----------------------------------------------------------------------------
module mirror_range_scanner #(
   parameter int DATA_W = 32,
   parameter int REV_W  = 34
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iChipSelect_n,
   input  logic              iWrite_n,
   input  logic              iRead_n,
   input  logic [1:0]        iAddress,
   input  logic [DATA_W-1:0] iData,
   output logic [DATA_W-1:0] oData
`ifdef MIRROR_IRQ_EN
   ,
   output logic              oIrq
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIGIT,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [DATA_W-1:0] low_q,   low_d;
   logic [DATA_W-1:0] high_q,  high_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] cand_q,  cand_d;
   logic [DATA_W-1:0] temp_q,  temp_d;
   logic [REV_W-1:0]  rev_q,   rev_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;
`ifdef MIRROR_IRQ_EN
   logic              irq_en_q, irq_en_d;
   logic              irq_q,    irq_d;
`endif

   // Bus decode
   logic wr_en, rd_en, ctrl_wr, start_req, abort_req;
   assign wr_en     = !iChipSelect_n && !iWrite_n;
   assign rd_en     = !iChipSelect_n && !iRead_n;
   assign ctrl_wr   = wr_en && (iAddress == 2'd2);
   assign start_req = ctrl_wr && iData[0];
   assign abort_req = ctrl_wr && iData[1];

   // One decimal digit step: peel the least significant digit off temp and
   // append it to the reversal accumulator.
   logic [DATA_W-1:0] temp_div10;
   logic [3:0]        digit;
   logic [REV_W-1:0]  rev_step;
   assign temp_div10 = temp_q / DATA_W'(10);
   assign digit      = 4'(temp_q - temp_div10 * DATA_W'(10));
   assign rev_step   = rev_q * REV_W'(10) + REV_W'(digit);

   logic              irq_en_bit;
   logic [DATA_W-1:0] status;
`ifdef MIRROR_IRQ_EN
   assign irq_en_bit = irq_en_q;
`else
   assign irq_en_bit = 1'b0;
`endif
   assign status = {{(DATA_W-4){1'b0}}, irq_en_bit, err_q, done_q, busy_q};

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      low_d   = low_q;
      high_d  = high_q;
      count_d = count_q;
      cand_d  = cand_q;
      temp_d  = temp_q;
      rev_d   = rev_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
`ifdef MIRROR_IRQ_EN
      irq_en_d = irq_en_q;
      irq_d    = irq_q;
`endif

      // Register reads: oData only changes on a sampled read
      if (rd_en) begin
         case (iAddress)
            2'd0:    data_d = low_q;
            2'd1:    data_d = high_q;
            2'd2:    data_d = status;
            default: data_d = count_q;
         endcase
      end

      // Range registers are frozen while a scan is running
      if (wr_en && !busy_q) begin
         if (iAddress == 2'd0) low_d  = iData;
         if (iAddress == 2'd1) high_d = iData;
      end

`ifdef MIRROR_IRQ_EN
      if (ctrl_wr) irq_en_d = iData[2];
      if (ctrl_wr || (rd_en && iAddress == 2'd2)) irq_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            // A simultaneous abort cancels the start
            if (start_req && !abort_req) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               count_d = '0;
               if (low_q > high_q) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cand_d  = low_q;
                  busy_d  = 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            temp_d  = cand_q;
            rev_d   = '0;
            // Candidate 0 has no digits to reverse
            state_d = (cand_q == '0) ? S_COMPARE : S_DIGIT;
         end
         S_DIGIT: begin
            temp_d = temp_div10;
            rev_d  = rev_step;
            // Leave as soon as the last digit has been consumed
            if (temp_div10 == '0) state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if ((rev_q == REV_W'(cand_q)) && (count_q != '1))
               count_d = count_q + 1'b1;
            // Stop on equality rather than on overflow so HIGH=all-ones never wraps
            if (cand_q == high_q) begin
               state_d = S_DONE;
            end else begin
               cand_d  = cand_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort preempts whatever the engine would have done this cycle,
      // including a pending COUNT increment in COMPARE.
      if (abort_req && busy_q) begin
         state_d = S_DONE;
         count_d = count_q;
      end

      // Entering DONE: the scan is over, done rises here
      if (state_d == S_DONE && state_q != S_DONE) begin
         busy_d = 1'b0;
         done_d = 1'b1;
`ifdef MIRROR_IRQ_EN
         // Setting takes priority over a same-cycle clear (e.g. the abort write)
         if (irq_en_q) irq_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         low_q    <= '0;
         high_q   <= '0;
         count_q  <= '0;
         cand_q   <= '0;
         temp_q   <= '0;
         rev_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef MIRROR_IRQ_EN
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         low_q    <= low_d;
         high_q   <= high_d;
         count_q  <= count_d;
         cand_q   <= cand_d;
         temp_q   <= temp_d;
         rev_q    <= rev_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef MIRROR_IRQ_EN
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
`endif
      end
   end

   assign oData = data_q;
`ifdef MIRROR_IRQ_EN
   assign oIrq  = irq_q;
`endif

endmodule

// File: tb/tb_mirror_range_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mirror_range_scanner
//
// Bus-level bench for mirror_range_scanner. Expected read data is queued when a
// read is issued and popped/compared when oData becomes valid. Palindrome
// counts and scan lengths come from a string-based reference model.
// -----------------------------------------------------------------------------
module tb_mirror_range_scanner;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs_n  = 1'b1;
   logic        wr_n  = 1'b1;
   logic        rd_n  = 1'b1;
   logic [1:0]  addr  = 2'd0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
`ifdef MIRROR_IRQ_EN
   logic        irq;
`endif

   mirror_range_scanner #(.DATA_W(32), .REV_W(34)) dut (
      .iClk          (clk),
      .iReset_n      (rst_n),
      .iChipSelect_n (cs_n),
      .iWrite_n      (wr_n),
      .iRead_n       (rd_n),
      .iAddress      (addr),
      .iData         (wdata),
      .oData         (rdata)
`ifdef MIRROR_IRQ_EN
      ,
      .oIrq          (irq)
`endif
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc is the index of the next rising edge
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_pal(input longint unsigned v);
      string s;
      int    n;
      s = $sformatf("%0d", v);
      n = s.len();
      for (int i = 0; i < n / 2; i++)
         if (s[i] != s[n-1-i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int cand_cycles(input longint unsigned v);
      string s;
      if (v == 0) return 2;
      s = $sformatf("%0d", v);
      return 2 + s.len();
   endfunction

   function automatic int count_pal(input longint unsigned lo, input longint unsigned hi);
      int c = 0;
      for (longint unsigned v = lo; v <= hi; v++) if (is_pal(v)) c++;
      return c;
   endfunction

   function automatic int scan_cycles(input longint unsigned lo, input longint unsigned hi);
      int c = 0;
      if (lo > hi) return 0;
      for (longint unsigned v = lo; v <= hi; v++) c += cand_cycles(v);
      return c;
   endfunction

   // COUNT after an abort sampled d edges after the start edge
   function automatic int partial_count(input longint unsigned lo, input int d);
      int e = 0;
      int c = 0;
      for (longint unsigned v = lo; ; v++) begin
         e += cand_cycles(v);
         if (e >= d) break;
         if (is_pal(v)) c++;
      end
      return c;
   endfunction

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int unsigned edge_no);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; addr = a; wdata = d;
      edge_no = cyc;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      $display("wr addr=%0d data=0x%08h", a, d);
   endtask

   task automatic bus_read_exp(input string tag, input logic [1:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      cs_n = 1'b0; rd_n = 1'b0; addr = a;
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1;
      $display("rd addr=%0d data=0x%08h (%s)", a, rdata, tag);
      check_val(tag_q.pop_front(), rdata, exp_q.pop_front());
   endtask

   // Reads STATUS every cycle right after a start write; counts busy samples
   task automatic poll_status(output int busy_cnt, output logic [31:0] last_st);
      busy_cnt = 0;
      last_st  = '0;
      cs_n = 1'b0; rd_n = 1'b0; addr = 2'd2;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         last_st = rdata;
         if (!rdata[0]) break;
         busy_cnt++;
      end
      cs_n = 1'b1; rd_n = 1'b1;
      if (last_st[0]) check_val("poll_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_scan(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                           input logic [31:0] ctrl);
      int unsigned e;
      int          bc;
      logic [31:0] st;
      logic [31:0] exp_st;
      bus_write(2'd0, lo, e);
      bus_write(2'd1, hi, e);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; addr = 2'd2; wdata = ctrl;
      @(negedge clk);
      wr_n = 1'b1;
      poll_status(bc, st);
      exp_st = (lo > hi) ? 32'h6 : 32'h2;
`ifdef MIRROR_IRQ_EN
      if (ctrl[2]) exp_st = exp_st | 32'h8;
`endif
      $display("scan %s lo=0x%08h hi=0x%08h busy_cycles=%0d", tag, lo, hi, bc);
      check_val({tag, "_busy"}, 32'(bc), 32'(scan_cycles(lo, hi)));
      check_val({tag, "_status"}, st, exp_st);
      bus_read_exp({tag, "_count"}, 2'd3, 32'(count_pal(lo, hi)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned ts, ta, e;
      int          part;

      repeat (3) @(negedge clk);
      check_val("odata_rst", rdata, 32'h0);
      rst_n = 1'b1;
      bus_read_exp("low_rst",    2'd0, 32'h0);
      bus_read_exp("high_rst",   2'd1, 32'h0);
      bus_read_exp("status_rst", 2'd2, 32'h0);
      bus_read_exp("count_rst",  2'd3, 32'h0);

      // Register readback and read-only COUNT
      bus_write(2'd0, 32'h1234_5678, e);
      bus_write(2'd1, 32'h9ABC_DEF0, e);
      bus_write(2'd3, 32'h0000_0055, e);
      bus_read_exp("low_rb",   2'd0, 32'h1234_5678);
      bus_read_exp("high_rb",  2'd1, 32'h9ABC_DEF0);
      bus_read_exp("count_ro", 2'd3, 32'h0);

      run_scan("s0_9",     32'd0,   32'd9,   32'h1);
      run_scan("s10_99",   32'd10,  32'd99,  32'h5);
      run_scan("s100_200", 32'd100, 32'd200, 32'h1);
      run_scan("s121",     32'd121, 32'd121, 32'h1);
      run_scan("s123",     32'd123, 32'd123, 32'h1);
      run_scan("serr",     32'd5,   32'd3,   32'h1);
      run_scan("stop",     32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1);

      // Abort mid-scan, with an ignored LOW write while busy
      bus_write(2'd0, 32'd0, e);
      bus_write(2'd1, 32'd100000, e);
      bus_write(2'd2, 32'h1, ts);
      repeat (18) @(negedge clk);
      bus_write(2'd0, 32'd7, e);
      repeat (15) @(negedge clk);
      bus_write(2'd2, 32'h2, ta);
      part = partial_count(0, int'(ta - ts));
      $display("abort after %0d edges, model count=%0d", ta - ts, part);
      bus_read_exp("abort_status", 2'd2, 32'h2);
      bus_read_exp("abort_count",  2'd3, 32'(part));
      bus_read_exp("abort_low",    2'd0, 32'd0);
      repeat (5) @(negedge clk);
      bus_read_exp("abort_count_stable", 2'd3, 32'(part));

      // start+abort while idle: nothing happens
      bus_write(2'd2, 32'h3, e);
      bus_read_exp("startabort_status", 2'd2, 32'h2);
      bus_read_exp("startabort_count",  2'd3, 32'(part));

`ifdef MIRROR_IRQ_EN
      bus_write(2'd0, 32'd0, e);
      bus_write(2'd1, 32'd9, e);
      bus_write(2'd2, 32'h5, ts);
      check_val("irq_low_busy", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 200; i++) begin
         if (irq) break;
         @(negedge clk);
      end
      check_val("irq_rise", {31'b0, irq}, 32'h1);
      check_val("irq_rise_edge", 32'(cyc - 1 - ts), 32'(scan_cycles(0, 9)));
      bus_read_exp("irq_status", 2'd2, 32'hA);
      check_val("irq_clr", {31'b0, irq}, 32'h0);
`endif

      // Reset mid-scan clears everything
      bus_write(2'd0, 32'd0, e);
      bus_write(2'd1, 32'd1000, e);
      bus_write(2'd2, 32'h5, e);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef MIRROR_IRQ_EN
      check_val("rst_irq", {31'b0, irq}, 32'h0);
`endif
      bus_read_exp("rst_status", 2'd2, 32'h0);
      bus_read_exp("rst_count",  2'd3, 32'h0);
      bus_read_exp("rst_high",   2'd1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
